// File: rtl/rggen_rtl_pkg.sv
// Shared access/status encodings for the bus adapter and register channels.
package rggen_rtl_pkg;
    typedef enum logic [1:0] {
        RGGEN_POSTED_WRITE = 2'b01,
        RGGEN_READ         = 2'b10,
        RGGEN_WRITE        = 2'b11
    } rggen_access;

    typedef enum logic [1:0] {
        RGGEN_OKAY         = 2'b00,
        RGGEN_EXOKAY       = 2'b01,
        RGGEN_SLAVE_ERROR  = 2'b10,
        RGGEN_DECODE_ERROR = 2'b11
    } rggen_status;
endpackage

// File: rtl/rggen_adapter_pipelined_if.sv
// Upstream bus and per-register channel interfaces used by the adapter.
interface rggen_bus_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32
);
    logic                          valid;
    rggen_rtl_pkg::rggen_access    access;
    logic [ADDRESS_WIDTH-1:0]      address;
    logic [BUS_WIDTH-1:0]          write_data;
    logic [BUS_WIDTH/8-1:0]        strobe;
    logic                          ready;
    rggen_rtl_pkg::rggen_status    status;
    logic [BUS_WIDTH-1:0]          read_data;

    modport master (
        output valid, access, address, write_data, strobe,
        input  ready, status, read_data
    );
    modport slave (
        input  valid, access, address, write_data, strobe,
        output ready, status, read_data
    );
endinterface

interface rggen_register_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32
);
    logic                          valid;
    rggen_rtl_pkg::rggen_access    access;
    logic [ADDRESS_WIDTH-1:0]      address;
    logic [BUS_WIDTH-1:0]          write_data;
    logic [BUS_WIDTH/8-1:0]        strobe;
    logic                          active;
    logic                          ready;
    rggen_rtl_pkg::rggen_status    status;
    logic [BUS_WIDTH-1:0]          read_data;

    modport host (
        output valid, access, address, write_data, strobe,
        input  active, ready, status, read_data
    );
    modport target (
        input  valid, access, address, write_data, strobe,
        output active, ready, status, read_data
    );
endinterface

// File: rtl/rggen_adapter_pipelined.sv
// Bus-to-register adapter with optional registered response, access
// watchdog and multi-hit detection, sequenced by an explicit FSM.
module rggen_adapter_pipelined
    import rggen_rtl_pkg::*;
#(
    parameter int                     ADDRESS_WIDTH       = 8,
    parameter int                     LOCAL_ADDRESS_WIDTH = 8,
    parameter int                     BUS_WIDTH           = 32,
    parameter int                     REGISTERS           = 1,
    parameter bit                     PRE_DECODE          = 0,
    parameter bit [ADDRESS_WIDTH-1:0] BASE_ADDRESS        = '0,
    parameter int                     BYTE_SIZE           = 256,
    parameter bit                     ERROR_STATUS        = 0,
    parameter bit [BUS_WIDTH-1:0]     DEFAULT_READ_DATA   = '0,
    parameter bit                     RESPONSE_REGISTER   = 0,
    parameter int                     TIMEOUT_CYCLES      = 0
)(
    input  logic            i_clk,
    input  logic            i_rst_n,
    rggen_bus_if.slave      bus_if,
    rggen_register_if.host  register_if[REGISTERS],
    output logic            o_timeout
);
    localparam bit [ADDRESS_WIDTH:0] END_ADDRESS =
        (ADDRESS_WIDTH+1)'(BASE_ADDRESS) + (ADDRESS_WIDTH+1)'(BYTE_SIZE - 1);
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TIMEOUT_LAST =
        CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESPOND} state_e;

    typedef struct packed {
        rggen_status          status;
        logic [BUS_WIDTH-1:0] read_data;
    } response_t;

    state_e                              state;
    state_e                              state_next;
    logic [CW-1:0]                       count;
    logic                                inside_range;
    logic                                reg_valid;
    logic [REGISTERS-1:0]                active;
    logic [REGISTERS-1:0]                ready;
    logic [REGISTERS-1:0][1:0]           status;
    logic [REGISTERS-1:0][BUS_WIDTH-1:0] read_data;
    logic [1:0]                          sel_status;
    logic [BUS_WIDTH-1:0]                sel_data;
    logic                                accepting;
    logic                                inactive;
    logic                                multi_hit;
    logic                                hit_ready;
    logic                                timeout_hit;
    logic                                complete;
    logic                                timeout_evt;
    response_t                           rsp;

    if (PRE_DECODE) begin : g_decode
        assign inside_range = ({1'b0, bus_if.address} >= {1'b0, BASE_ADDRESS}) &&
                              ({1'b0, bus_if.address} <= END_ADDRESS);
    end else begin : g_no_decode
        assign inside_range = 1'b1;
    end

    // Only a fresh request from IDLE strobes the registers, so valid is one cycle per access.
    assign reg_valid = bus_if.valid && inside_range && (state == ST_IDLE);

    for (genvar g = 0; g < REGISTERS; g++) begin : g_ch
        assign register_if[g].valid      = reg_valid;
        assign register_if[g].access     = bus_if.access;
        assign register_if[g].address    = bus_if.address[LOCAL_ADDRESS_WIDTH-1:0];
        assign register_if[g].write_data = bus_if.write_data;
        assign register_if[g].strobe     = bus_if.strobe;
        assign active[g]                 = register_if[g].active;
        assign ready[g]                  = register_if[g].ready;
        assign status[g]                 = register_if[g].status;
        assign read_data[g]              = register_if[g].read_data;
    end

    // OR-select the active channel's response; only meaningful on a single hit.
    always_comb begin
        sel_status = '0;
        sel_data   = '0;
        for (int i = 0; i < REGISTERS; i++) begin
            if (active[i]) begin
                sel_status = sel_status | status[i];
                sel_data   = sel_data | read_data[i];
            end
        end
    end

    assign accepting   = bus_if.valid && ((state == ST_IDLE) || (state == ST_WAIT));
    assign inactive    = !inside_range || (active == '0);
    assign multi_hit   = (active & (active - REGISTERS'(1))) != '0;
    assign hit_ready   = |(active & ready);
    assign timeout_hit = (TIMEOUT_CYCLES > 0) && (state == ST_WAIT) && (count == TIMEOUT_LAST);

    // Completion arbitration: inactive > multi-hit > ready > timeout.
    always_comb begin
        complete      = 1'b0;
        timeout_evt   = 1'b0;
        rsp.status    = RGGEN_OKAY;
        rsp.read_data = DEFAULT_READ_DATA;
        if (accepting) begin
            if (inactive) begin
                complete   = 1'b1;
                rsp.status = ERROR_STATUS ? RGGEN_SLAVE_ERROR : RGGEN_OKAY;
            end else if (multi_hit) begin
                complete   = 1'b1;
                rsp.status = RGGEN_SLAVE_ERROR;
            end else if (hit_ready) begin
                complete      = 1'b1;
                rsp.status    = rggen_status'(sel_status);
                rsp.read_data = sel_data;
            end else if (timeout_hit) begin
                complete    = 1'b1;
                timeout_evt = 1'b1;
                rsp.status  = RGGEN_SLAVE_ERROR;
            end
        end
    end

    assign o_timeout = timeout_evt;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_WAIT: begin
                if (complete)          state_next = RESPONSE_REGISTER ? ST_RESPOND : ST_IDLE;
                else if (bus_if.valid) state_next = ST_WAIT;
            end
            ST_RESPOND: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Watchdog: counts WAIT cycles, saturating at the firing value.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                                             count <= '0;
        else if (state != ST_WAIT)                                count <= '0;
        else if ((TIMEOUT_CYCLES > 0) && (count != TIMEOUT_LAST)) count <= count + CW'(1);
    end

    if (RESPONSE_REGISTER) begin : g_rsp_reg
        response_t rsp_q;

        // Capture the response at completion; present it from RESPOND.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                rsp_q.status    <= RGGEN_OKAY;
                rsp_q.read_data <= '0;
            end else if (complete) begin
                rsp_q <= rsp;
            end
        end

        assign bus_if.ready     = (state == ST_RESPOND);
        assign bus_if.status    = rsp_q.status;
        assign bus_if.read_data = rsp_q.read_data;
    end else begin : g_rsp_comb
        assign bus_if.ready     = complete;
        assign bus_if.status    = rsp.status;
        assign bus_if.read_data = rsp.read_data;
    end
endmodule

// File: tb/tb_rggen_adapter_pipelined.sv
// Self-checking bench: three adapter configurations share one stimulus set;
// a negedge monitor scores the selected instance against an expectation queue.
module tb_rggen_adapter_pipelined;
    import rggen_rtl_pkg::*;

    localparam int AW = 16, LAW = 8, BW = 32, NR = 4;
    localparam logic [BW-1:0] DEF = 32'h0BAD_F00D;

    typedef struct {
        rggen_status   status;
        logic [BW-1:0] data;
        logic          to;
    } exp_t;

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    always #5 i_clk = ~i_clk;

    // shared stimulus
    logic                   valid;
    rggen_access            access;
    logic [AW-1:0]          addr;
    logic [BW-1:0]          wdata;
    logic [BW/8-1:0]        strb;
    logic [NR-1:0]          act, rdy;
    logic [NR-1:0][1:0]     st;
    logic [NR-1:0][BW-1:0]  rd;

    int   sel;
    int   cyc, resp_cyc, resp_cnt, rvld_cnt, to_cnt;
    int   total, passed;
    exp_t q[$];

    logic to0, to1, to2;
    logic [NR-1:0] rvld0, rvld1, rvld2;

    rggen_bus_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) bif0(), bif1(), bif2();
    rggen_register_if #(.ADDRESS_WIDTH(LAW), .BUS_WIDTH(BW)) rif0[NR](), rif1[NR](), rif2[NR]();

    assign bif0.valid = valid; assign bif0.access = access; assign bif0.address = addr;
    assign bif0.write_data = wdata; assign bif0.strobe = strb;
    assign bif1.valid = valid; assign bif1.access = access; assign bif1.address = addr;
    assign bif1.write_data = wdata; assign bif1.strobe = strb;
    assign bif2.valid = valid; assign bif2.access = access; assign bif2.address = addr;
    assign bif2.write_data = wdata; assign bif2.strobe = strb;

    for (genvar g = 0; g < NR; g++) begin : g_reg
        assign rif0[g].active = act[g]; assign rif0[g].ready = rdy[g];
        assign rif0[g].status = rggen_status'(st[g]); assign rif0[g].read_data = rd[g];
        assign rif1[g].active = act[g]; assign rif1[g].ready = rdy[g];
        assign rif1[g].status = rggen_status'(st[g]); assign rif1[g].read_data = rd[g];
        assign rif2[g].active = act[g]; assign rif2[g].ready = rdy[g];
        assign rif2[g].status = rggen_status'(st[g]); assign rif2[g].read_data = rd[g];
        assign rvld0[g] = rif0[g].valid;
        assign rvld1[g] = rif1[g].valid;
        assign rvld2[g] = rif2[g].valid;
    end

    rggen_adapter_pipelined #(
        .ADDRESS_WIDTH(AW), .LOCAL_ADDRESS_WIDTH(LAW), .BUS_WIDTH(BW), .REGISTERS(NR),
        .DEFAULT_READ_DATA(DEF), .TIMEOUT_CYCLES(5)
    ) dut0 (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus_if(bif0), .register_if(rif0), .o_timeout(to0));

    rggen_adapter_pipelined #(
        .ADDRESS_WIDTH(AW), .LOCAL_ADDRESS_WIDTH(LAW), .BUS_WIDTH(BW), .REGISTERS(NR),
        .DEFAULT_READ_DATA(DEF), .RESPONSE_REGISTER(1)
    ) dut1 (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus_if(bif1), .register_if(rif1), .o_timeout(to1));

    rggen_adapter_pipelined #(
        .ADDRESS_WIDTH(AW), .LOCAL_ADDRESS_WIDTH(LAW), .BUS_WIDTH(BW), .REGISTERS(NR),
        .PRE_DECODE(1), .BASE_ADDRESS(16'h0100), .BYTE_SIZE(16'h0040), .ERROR_STATUS(1),
        .DEFAULT_READ_DATA(DEF)
    ) dut2 (.i_clk(i_clk), .i_rst_n(i_rst_n), .bus_if(bif2), .register_if(rif2), .o_timeout(to2));

    // selected-instance view
    logic          s_ready, s_to;
    rggen_status   s_status;
    logic [BW-1:0] s_rdata, s_wdata;
    logic [NR-1:0] s_rvld;
    logic [LAW-1:0] s_raddr;
    assign s_ready  = (sel == 0) ? bif0.ready     : (sel == 1) ? bif1.ready     : bif2.ready;
    assign s_status = (sel == 0) ? bif0.status    : (sel == 1) ? bif1.status    : bif2.status;
    assign s_rdata  = (sel == 0) ? bif0.read_data : (sel == 1) ? bif1.read_data : bif2.read_data;
    assign s_to     = (sel == 0) ? to0            : (sel == 1) ? to1            : to2;
    assign s_rvld   = (sel == 0) ? rvld0          : (sel == 1) ? rvld1          : rvld2;
    assign s_raddr  = (sel == 0) ? rif0[0].address    : (sel == 1) ? rif1[0].address    : rif2[0].address;
    assign s_wdata  = (sel == 0) ? rif0[0].write_data : (sel == 1) ? rif1[0].write_data : rif2[0].write_data;

    always @(posedge i_clk) cyc <= cyc + 1;

    // scoreboard monitor
    always @(negedge i_clk) begin
        exp_t e;
        if (s_to) to_cnt++;
        if (|s_rvld) rvld_cnt++;
        if (s_ready) begin
            resp_cnt++;
            resp_cyc = cyc;
            if (q.size() == 0) begin
                total++;
                $display("FAIL unexpected_ready: got ready=1 at cycle %0d, want no response", cyc);
            end else begin
                e = q.pop_front();
                total++;
                if (s_status !== e.status) $display("FAIL rsp_status: got %0d want %0d", s_status, e.status);
                else passed++;
                total++;
                if (s_rdata !== e.data) $display("FAIL rsp_data: got %08h want %08h", s_rdata, e.data);
                else passed++;
                total++;
                if (s_to !== e.to) $display("FAIL rsp_timeout: got %0b want %0b", s_to, e.to);
                else passed++;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge i_clk); #1; end
    endtask

    task automatic idle_stim();
        valid = 1'b0; access = RGGEN_READ; addr = '0; wdata = '0; strb = '0;
        act = '0; rdy = '0; st = '0; rd = '0;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        idle_stim();
        tick(2);
        i_rst_n = 1'b1;
        tick(1);
        rvld_cnt = 0; to_cnt = 0; resp_cnt = 0; resp_cyc = -1;
    endtask

    task automatic push(input rggen_status s, input logic [BW-1:0] d, input logic t);
        exp_t e;
        e.status = s; e.data = d; e.to = t;
        q.push_back(e);
    endtask

    task automatic test_reset();
        sel = 0;
        i_rst_n = 1'b0;
        idle_stim();
        tick(2);
        @(negedge i_clk);
        total++;
        if (bif0.ready !== 1'b0) $display("FAIL reset_ready0: got %0b want 0", bif0.ready); else passed++;
        total++;
        if (to0 !== 1'b0) $display("FAIL reset_timeout: got %0b want 0", to0); else passed++;
        total++;
        if (bif1.ready !== 1'b0) $display("FAIL reset_ready1: got %0b want 0", bif1.ready); else passed++;
        total++;
        if (bif1.status !== RGGEN_OKAY) $display("FAIL reset_status1: got %0d want 0", bif1.status); else passed++;
        total++;
        if (bif1.read_data !== '0) $display("FAIL reset_rdata1: got %08h want 0", bif1.read_data); else passed++;
        total++;
        if (rvld0 !== '0) $display("FAIL reset_reg_valid: got %b want 0", rvld0); else passed++;
        i_rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_same_cycle_read();
        int t0;
        sel = 0; do_reset();
        t0 = cyc;
        valid = 1'b1; access = RGGEN_READ; addr = 16'h0008;
        act = 4'b0100; rdy = 4'b0100; st[2] = RGGEN_OKAY; rd[2] = 32'hDEAD_BEEF;
        push(RGGEN_OKAY, 32'hDEAD_BEEF, 1'b0);
        tick(1);
        idle_stim();
        tick(3);
        total++;
        if (resp_cyc - t0 !== 0) $display("FAIL read_latency: got %0d want 0", resp_cyc - t0); else passed++;
        total++;
        if (rvld_cnt !== 1) $display("FAIL read_reg_valid_cycles: got %0d want 1", rvld_cnt); else passed++;
    endtask

    task automatic test_registered_response();
        int t0;
        sel = 1; do_reset();
        t0 = cyc;
        valid = 1'b1; access = RGGEN_READ; addr = 16'h0004;
        act = 4'b0010; rd[1] = 32'h1111_2222; st[1] = RGGEN_SLAVE_ERROR;
        push(RGGEN_SLAVE_ERROR, 32'h1111_2222, 1'b0);
        tick(3);
        rdy = 4'b0010;
        tick(1);
        rdy = '0;
        tick(1);
        idle_stim();
        tick(2);
        total++;
        if (resp_cyc - t0 !== 4) $display("FAIL rr_latency: got %0d want 4", resp_cyc - t0); else passed++;
        total++;
        if (rvld_cnt !== 1) $display("FAIL rr_reg_valid_cycles: got %0d want 1", rvld_cnt); else passed++;
    endtask

    task automatic test_back_to_back();
        int t0;
        logic [BW-1:0] w;
        sel = 1; do_reset();
        for (int i = 0; i < 4; i++) begin
            t0 = cyc;
            w = 32'hA500_0000 + 32'(i);
            valid = 1'b1; access = RGGEN_WRITE; addr = 16'(4 * i); wdata = w; strb = '1;
            act = 4'b0001; rdy = 4'b0001; st[0] = RGGEN_OKAY; rd[0] = 32'(i);
            push(RGGEN_OKAY, 32'(i), 1'b0);
            @(negedge i_clk);
            total++;
            if (s_wdata !== w) $display("FAIL b2b_wdata: got %08h want %08h", s_wdata, w); else passed++;
            tick(2);
            total++;
            if (resp_cyc !== t0 + 1) $display("FAIL b2b_ready_cycle: got %0d want %0d", resp_cyc, t0 + 1); else passed++;
        end
        idle_stim();
        tick(2);
        total++;
        if (resp_cnt !== 4) $display("FAIL b2b_count: got %0d want 4", resp_cnt); else passed++;
        total++;
        if (rvld_cnt !== 4) $display("FAIL b2b_reg_valid_cycles: got %0d want 4", rvld_cnt); else passed++;
    endtask

    task automatic test_window();
        int t0;
        sel = 2; do_reset();
        t0 = cyc;
        valid = 1'b1; access = RGGEN_READ; addr = 16'h0140; act = 4'b0001;
        push(RGGEN_SLAVE_ERROR, DEF, 1'b0);
        tick(1);
        idle_stim();
        tick(1);
        total++;
        if (resp_cyc - t0 !== 0) $display("FAIL oor_latency: got %0d want 0", resp_cyc - t0); else passed++;
        total++;
        if (rvld_cnt !== 0) $display("FAIL oor_reg_valid: got %0d want 0", rvld_cnt); else passed++;
        t0 = cyc;
        valid = 1'b1; addr = 16'h013C; act = 4'b0001; rdy = 4'b0001; rd[0] = 32'h1234_5678;
        push(RGGEN_OKAY, 32'h1234_5678, 1'b0);
        @(negedge i_clk);
        total++;
        if (s_raddr !== 8'h3C) $display("FAIL local_address: got %02h want 3c", s_raddr); else passed++;
        tick(1);
        idle_stim();
        tick(1);
        total++;
        if (resp_cyc - t0 !== 0) $display("FAIL inwin_latency: got %0d want 0", resp_cyc - t0); else passed++;
        total++;
        if (rvld_cnt !== 1) $display("FAIL inwin_reg_valid: got %0d want 1", rvld_cnt); else passed++;
    endtask

    task automatic test_timeout();
        int t0;
        sel = 0; do_reset();
        t0 = cyc;
        valid = 1'b1; access = RGGEN_READ; addr = 16'h0010; act = 4'b0001; rd[0] = 32'h5555_AAAA;
        push(RGGEN_SLAVE_ERROR, DEF, 1'b1);
        tick(6);
        valid = 1'b0;
        tick(1);
        rdy = 4'b0001;
        tick(1);
        rdy = '0;
        tick(2);
        total++;
        if (resp_cyc - t0 !== 5) $display("FAIL timeout_latency: got %0d want 5", resp_cyc - t0); else passed++;
        total++;
        if (to_cnt !== 1) $display("FAIL timeout_pulses: got %0d want 1", to_cnt); else passed++;
        total++;
        if (resp_cnt !== 1) $display("FAIL late_ready_ignored: got %0d responses want 1", resp_cnt); else passed++;
        t0 = cyc;
        valid = 1'b1; act = 4'b0001; st[0] = RGGEN_OKAY;
        push(RGGEN_OKAY, 32'h5555_AAAA, 1'b0);
        tick(5);
        rdy = 4'b0001;
        tick(1);
        idle_stim();
        tick(2);
        total++;
        if (resp_cyc - t0 !== 5) $display("FAIL edge_ready_latency: got %0d want 5", resp_cyc - t0); else passed++;
        total++;
        if (to_cnt !== 1) $display("FAIL edge_ready_no_timeout: got %0d want 1", to_cnt); else passed++;
    endtask

    task automatic test_multi_hit();
        int t0;
        sel = 0; do_reset();
        t0 = cyc;
        valid = 1'b1; access = RGGEN_READ; addr = 16'h0020; act = 4'b1001; rdy = 4'b1001;
        rd[0] = 32'h0000_0001; rd[3] = 32'h0000_0008;
        push(RGGEN_SLAVE_ERROR, DEF, 1'b0);
        tick(1);
        idle_stim();
        tick(1);
        total++;
        if (resp_cyc - t0 !== 0) $display("FAIL multihit_latency: got %0d want 0", resp_cyc - t0); else passed++;
    endtask

    task automatic test_reset_mid_access();
        int t0;
        sel = 0; do_reset();
        valid = 1'b1; access = RGGEN_READ; addr = 16'h0030; act = 4'b0001;
        tick(2);
        #2 i_rst_n = 1'b0;
        #1;
        total++;
        if (bif0.ready !== 1'b0) $display("FAIL midreset_ready: got %0b want 0", bif0.ready); else passed++;
        tick(6);
        total++;
        if (to_cnt !== 0) $display("FAIL midreset_no_timeout: got %0d want 0", to_cnt); else passed++;
        valid = 1'b0;
        tick(1);
        i_rst_n = 1'b1;
        tick(1);
        t0 = cyc;
        valid = 1'b1; addr = 16'h0034; act = 4'b0001; rd[0] = 32'hCAFE_0001; st[0] = RGGEN_OKAY;
        push(RGGEN_OKAY, 32'hCAFE_0001, 1'b0);
        tick(2);
        rdy = 4'b0001;
        tick(1);
        idle_stim();
        tick(2);
        total++;
        if (resp_cyc - t0 !== 2) $display("FAIL post_reset_latency: got %0d want 2", resp_cyc - t0); else passed++;
    endtask

    initial begin
        cyc = 0; total = 0; passed = 0; sel = 0;
        rvld_cnt = 0; to_cnt = 0; resp_cnt = 0; resp_cyc = -1;
        idle_stim();
        test_reset();
        test_same_cycle_read();
        test_registered_response();
        test_back_to_back();
        test_window();
        test_timeout();
        test_multi_hit();
        test_reset_mid_access();
        total++;
        if (q.size() != 0) $display("FAIL pending_expectations: got %0d want 0", q.size()); else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/rggen_adapter_pipelined.md
# rggen_adapter_pipelined

Parametrised bus-to-register adapter sitting between a protocol-specific bus front end (through `rggen_bus_if`) and the register array (through `rggen_register_if`). It extends the common adapter with:
- an optional registered response stage;
- a per-access timeout watchdog;
- a multi-hit error check.

An explicit state machine replaces the single busy flag.

## Interface
- ADDRESS_WIDTH, 8, bus address width.
- LOCAL_ADDRESS_WIDTH, 8, address bits forwarded to registers (LSBs).
- BUS_WIDTH, 32, data width.
- REGISTERS, 1, number of `register_if` channels.
- PRE_DECODE, 0, 1: accesses outside [BASE_ADDRESS, BASE_ADDRESS+BYTE_SIZE-1] are out of range.
- BASE_ADDRESS, '0, window base, ADDRESS_WIDTH bits.
- BYTE_SIZE, 256, window size in bytes.
- ERROR_STATUS, 0, 1: unmapped or out-of-range accesses return RGGEN_SLAVE_ERROR; 0: they return RGGEN_OKAY.
- DEFAULT_READ_DATA, '0, read data for unmapped, out-of-range, timed-out and multi-hit accesses.
- RESPONSE_REGISTER, 0, 1: response is registered (+1 cycle).
- TIMEOUT_CYCLES, 0, watchdog limit in cycles; 0 disables it. Counter width is $clog2(TIMEOUT_CYCLES+1).
- i_clk  input  1  clock.
- i_rst_n  input  1  reset, asynchronous, active-low.
- bus_if  rggen_bus_if.slave  -  upstream bus.
- register_if  rggen_register_if.host  [REGISTERS]  register channels.
- o_timeout  output  1  one-cycle pulse when an access is terminated by the watchdog.

## Operation
- State machine: IDLE, WAIT, RESPOND (RESPOND exists only when RESPONSE_REGISTER=1).
- Request:
  - `register_if[i].valid` = bus_if.valid & inside_range & (state==IDLE), broadcast to all channels.
  - access, address[LOCAL_ADDRESS_WIDTH-1:0], write_data and strobe pass straight through.
- Hit classes, evaluated every cycle while bus_if.valid is high:
  - inactive: !inside_range, or active==0.
  - multi-hit: more than one active bit.
  - normal: exactly one active bit.
- Completion event, in IDLE or WAIT:
  - inactive: returns DEFAULT status (per ERROR_STATUS) and DEFAULT_READ_DATA.
  - multi-hit: returns RGGEN_SLAVE_ERROR and DEFAULT_READ_DATA.
  - normal with ready of the active channel: returns that channel's status and read_data.
  - timeout: returns RGGEN_SLAVE_ERROR and DEFAULT_READ_DATA, and pulses o_timeout.
- Priority when events coincide: inactive > multi-hit > ready > timeout. A ready arriving in the same cycle as the timeout wins.
- Transitions:
  - IDLE→WAIT: bus_if.valid high and no completion.
  - IDLE/WAIT→IDLE: completion with RESPONSE_REGISTER=0.
  - IDLE/WAIT→RESPOND: completion with RESPONSE_REGISTER=1.
  - RESPOND→IDLE: always.
- Response presentation:
  - RESPONSE_REGISTER=0: bus_if.ready/status/read_data are driven combinationally in the completion cycle.
  - RESPONSE_REGISTER=1: status/read_data are captured into flops at completion. bus_if.ready=1 only in RESPOND, with outputs taken from those flops.
- bus_if.ready is 0 whenever no completion is being presented, including IDLE without valid.
- Watchdog:
  - Counter is cleared in IDLE and increments each WAIT cycle.
  - Timeout fires when the counter equals TIMEOUT_CYCLES-1 in WAIT, i.e. the TIMEOUT_CYCLES-th cycle after the request cycle.
  - A ready arriving after a timeout is ignored.
  - TIMEOUT_CYCLES=0: no timeout, WAIT lasts indefinitely.
- Upstream master must hold valid/access/address/write_data stable until ready. The adapter does not re-check this.

## Timing
- Reset values: state IDLE, counter 0, o_timeout 0, response flops status RGGEN_OKAY and read_data 0, bus_if.ready 0, register valid 0.
- Reset mid-access: state returns to IDLE immediately, pending response is dropped, no o_timeout.
- Request in cycle t with register ready in t:
  - RESPONSE_REGISTER=0: bus_if.ready in t.
  - RESPONSE_REGISTER=1: bus_if.ready in t+1.
- Register ready in t+k: bus_if.ready in t+k (+1 when RESPONSE_REGISTER=1).
- Register valid is high exactly one cycle per access (cycle t).
- Back-to-back throughput:
  - RESPONSE_REGISTER=0: a new request can issue in the cycle after ready.
  - RESPONSE_REGISTER=1: one access per 2 cycles minimum.
- o_timeout is high in the timeout completion cycle itself, regardless of RESPONSE_REGISTER.

## Test plan
- REGISTERS=4, RESPONSE_REGISTER=0: read addr 0x08, channel 2 active with ready in the same cycle and read_data 0xDEADBEEF -> bus_if.ready in the same cycle, read_data 0xDEADBEEF, status OKAY, register valid high 1 cycle.
- RESPONSE_REGISTER=1, channel 1 ready 3 cycles after the request, status SLAVE_ERROR -> bus ready 4 cycles after the request, status SLAVE_ERROR. Back-to-back writes complete on every 2nd cycle.
- PRE_DECODE=1, BASE_ADDRESS=0x100, BYTE_SIZE=0x40, ERROR_STATUS=1: access to 0x140 -> register valid never high, ready in the same cycle, SLAVE_ERROR, DEFAULT_READ_DATA. Access to 0x13C -> forwarded with local address 0x3C.
- TIMEOUT_CYCLES=5, register never ready -> bus ready and o_timeout pulse 5 cycles after the request, SLAVE_ERROR. A late ready 2 cycles later is ignored. A repeat with ready in the 5th cycle -> normal response, no o_timeout.
- Channels 0 and 3 both active -> SLAVE_ERROR with DEFAULT_READ_DATA in the request cycle.
- i_rst_n asserted while in WAIT -> bus ready 0 and state IDLE. After release, a new access completes normally.
